reverse_order_scheduler: RTL and testbench
==========================================

# reverse_order_scheduler

Frame-granular round-robin scheduler that shares one `reverse_order_vector` datapath among R requesters. It grants the datapath to one requester at a time for exactly one N-beat frame and muxes that requester's V-lane beats into the datapath. It also tracks which requester owns each frame in flight, so that reversed output beats are steered back to the owner. It sits between the requester channels and a single `reverse_order_vector` instance.

## Interface
- `BITS`, 8, lane width
- `N`, 10, beats per frame (≥2)
- `V`, 2, lanes per beat
- `R`, 4, number of requesters (≥2)
- `TAGD`, 4, frames in flight tracked (tag FIFO depth, power of 2)

- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `req`  in  R  requester r wants to send a frame (level)
- `in_valid`  in  R  per-requester beat valid
- `data_in`  in  [R][V]×BITS  per-requester beat data
- `grant`  out  R  one-hot registered grant; zero when idle
- `dp_in_valid`  out  1  to datapath `in_valid`
- `dp_data`  out  [V]×BITS  to datapath `data_in`
- `dp_out_valid`  in  1  from datapath `out_valid`
- `out_valid`  out  R  demuxed output-beat valid to the frame owner
- `out_id`  out  $clog2(R)  owner of the current output beat (tag FIFO head)
- `busy`  out  1  a grant is active or the tag FIFO is non-empty
- `err`  out  1  sticky: `dp_out_valid` seen while no frame was in flight

## Operation
- States: IDLE, STREAM.
- IDLE:
  - If any `req` is set and the tag FIFO is not full, pick the first requesting index after `last_id`, wrapping round-robin.
  - Register `grant` one-hot and `gnt_id`, push `gnt_id` into the tag FIFO, and go to STREAM.
- STREAM:
  - `dp_in_valid = in_valid[gnt_id]` and `dp_data = data_in[gnt_id]`. Both are combinational, so there is zero added latency.
  - Beats from non-granted requesters are ignored.
  - `in_cnt` (0..N-1) increments on each accepted beat. Gaps between beats are allowed.
  - On the beat where `in_cnt == N-1`: clear `in_cnt`, set `last_id = gnt_id`, drop `grant` on the next edge, and return to IDLE.
- `dp_data` is held at 0 and `dp_in_valid` at 0 whenever `grant == 0`.
- `req` is sampled only in IDLE. Dropping `req` mid-frame does not end the grant; the frame must still complete N beats.
- Output side:
  - `out_valid[r] = dp_out_valid && tag_nonempty && head == r`.
  - `out_cnt` (0..N-1) counts `dp_out_valid` beats. On the N-th beat, pop the tag FIFO and clear `out_cnt`.
- Error: `dp_out_valid` with an empty tag FIFO sets `err` (sticky until reset). That beat is not routed, and `out_cnt` does not advance.
- Simultaneous events:
  - A tag push (grant) and a pop (last output beat) in the same cycle are both performed; occupancy is unchanged.
  - A full FIFO blocks only new grants, never a pop.
- Counters wrap explicitly at N-1, never at a power of 2. The tag FIFO pointers wrap modulo TAGD, with a separate occupancy count of $clog2(TAGD)+1 bits.

## Timing
- Reset (async assert, sync release): state=IDLE; `grant`=0; `in_cnt`=`out_cnt`=0; tag FIFO empty; `last_id`=R-1 (so requester 0 wins first); `err`=0; `busy`=0.
- Combinational outputs evaluate to 0 under reset: `dp_in_valid`=0, `out_valid`=0, `out_id`=0, `dp_data`=0.
- Grant latency: `req` seen in IDLE at edge k → `grant` high after edge k+1. The first beat can be accepted in cycle k+1.
- End of frame: the last beat is accepted at edge m → `grant`=0 after m+1. The earliest next grant is after m+2, giving one idle cycle between frames.
- Reset mid-frame clears all controller state immediately. The datapath must be reset or drained alongside it; any later stale `dp_out_valid` sets `err`.

## Test plan
- Single frame: `req[2]`=1 with N=10 contiguous beats (lane0=i, lane1=100+i).
  - Expect `grant`=0100 for exactly 10 accepted beats and `dp_data` equal to the input beats.
  - Expect `out_valid[2]` on all 10 reversed beats, `out_id`=2, then `busy`=0.
- Round-robin: `req`=1111 held for 8 frames.
  - Expect grant order 0,1,2,3,0,1,2,3, one idle cycle between frames.
  - Expect output frames tagged in the same order.
- Gapped input: requester 1 sends beats with `in_valid` toggling 1,0,1,0.
  - Expect the grant to hold until 10 valid beats have been counted.
  - Expect beats from requester 3 driven in the same window to be absent from `dp_in_valid`.
- Tag FIFO full: TAGD=2 and the datapath output stalled (`dp_out_valid`=0).
  - Expect 2 frames granted and a third `req` not granted until the first output frame's 10th beat pops the FIFO.
  - On that pop cycle, with a grant occurring at the same time, occupancy must stay at 2.
- Error and reset: pulse `dp_out_valid` with no frame in flight → `err`=1, `out_valid`=0.
  - Assert `rst_n`=0 mid-STREAM at beat 4 → `grant`=0 and `err`=0 asynchronously.
  - After release, `req[0]` is granted first.

Source files
------------

// File: rtl/reverse_order_scheduler.sv
// Frame-granular round-robin front end that shares one reverse_order_vector datapath
// among R requesters, steering each reversed output frame back to its owner via a tag FIFO.
module reverse_order_scheduler #(
   parameter int unsigned BITS = 8,
   parameter int unsigned N    = 10,
   parameter int unsigned V    = 2,
   parameter int unsigned R    = 4,
   parameter int unsigned TAGD = 4
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic [R-1:0]                     req,
   input  logic [R-1:0]                     in_valid,
   input  logic [R-1:0][V-1:0][BITS-1:0]    data_in,
   output logic [R-1:0]                     grant,
   output logic                             dp_in_valid,
   output logic [V-1:0][BITS-1:0]           dp_data,
   input  logic                             dp_out_valid,
   output logic [R-1:0]                     out_valid,
   output logic [$clog2(R)-1:0]             out_id,
   output logic                             busy,
   output logic                             err
);
   localparam int unsigned ID_W  = $clog2(R);
   localparam int unsigned CNT_W = $clog2(N);
   localparam int unsigned PTR_W = $clog2(TAGD);
   localparam int unsigned OCC_W = PTR_W + 1;

   typedef enum logic {IDLE, STREAM} state_t;

   state_t            state_q, state_d;
   logic [R-1:0]      grant_q, grant_d;
   logic [ID_W-1:0]   gnt_id_q, gnt_id_d;
   logic [ID_W-1:0]   last_id_q, last_id_d;
   logic [CNT_W-1:0]  in_cnt_q, in_cnt_d;
   logic [CNT_W-1:0]  out_cnt_q, out_cnt_d;
   logic [ID_W-1:0]   tag_q [TAGD];
   logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
   logic [OCC_W-1:0]  occ_q;
   logic              err_q, err_d;

   logic              full, nonempty, push, pop;
   logic [ID_W-1:0]   head, idx, pick_id;
   logic              pick_vld;

   assign full     = (occ_q == OCC_W'(TAGD));
   assign nonempty = (occ_q != '0);
   assign head     = tag_q[rd_ptr_q];

   // Round-robin search starting just after the previous frame owner.
   always_comb begin
      pick_vld = 1'b0;
      pick_id  = '0;
      idx      = '0;
      for (int unsigned i = 1; i <= R; i++) begin
         idx = ID_W'((32'(last_id_q) + i) % R);
         if (!pick_vld && req[idx]) begin
            pick_vld = 1'b1;
            pick_id  = idx;
         end
      end
   end

   always_comb begin
      dp_in_valid = 1'b0;
      dp_data     = '0;
      if (grant_q != '0) begin
         dp_in_valid = in_valid[gnt_id_q];
         dp_data     = data_in[gnt_id_q];
      end
   end

   // Output side: the last beat of the head frame frees its tag in the same cycle.
   always_comb begin
      out_cnt_d = out_cnt_q;
      pop       = 1'b0;
      err_d     = err_q;
      if (dp_out_valid) begin
         if (nonempty) begin
            if (out_cnt_q == CNT_W'(N - 1)) begin
               out_cnt_d = '0;
               pop       = 1'b1;
            end else begin
               out_cnt_d = out_cnt_q + CNT_W'(1);
            end
         end else begin
            err_d = 1'b1;
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      grant_d   = grant_q;
      gnt_id_d  = gnt_id_q;
      last_id_d = last_id_q;
      in_cnt_d  = in_cnt_q;
      push      = 1'b0;
      unique case (state_q)
         IDLE: begin
            // A pop in this cycle frees a slot, so a full FIFO does not block here.
            if (pick_vld && (!full || pop)) begin
               grant_d  = R'(1) << pick_id;
               gnt_id_d = pick_id;
               push     = 1'b1;
               state_d  = STREAM;
            end
         end
         STREAM: begin
            if (dp_in_valid) begin
               if (in_cnt_q == CNT_W'(N - 1)) begin
                  in_cnt_d  = '0;
                  last_id_d = gnt_id_q;
                  grant_d   = '0;
                  state_d   = IDLE;
               end else begin
                  in_cnt_d = in_cnt_q + CNT_W'(1);
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         grant_q   <= '0;
         gnt_id_q  <= '0;
         last_id_q <= ID_W'(R - 1);
         in_cnt_q  <= '0;
         out_cnt_q <= '0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         grant_q   <= grant_d;
         gnt_id_q  <= gnt_id_d;
         last_id_q <= last_id_d;
         in_cnt_q  <= in_cnt_d;
         out_cnt_q <= out_cnt_d;
         err_q     <= err_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < TAGD; i++) tag_q[i] <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         occ_q    <= '0;
      end else begin
         if (push) begin
            tag_q[wr_ptr_q] <= pick_id;
            wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
         end
         if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         unique case ({push, pop})
            2'b10:   occ_q <= occ_q + OCC_W'(1);
            2'b01:   occ_q <= occ_q - OCC_W'(1);
            default: occ_q <= occ_q;
         endcase
      end
   end

   always_comb begin
      out_valid = '0;
      for (int unsigned r = 0; r < R; r++) begin
         out_valid[r] = dp_out_valid && nonempty && (head == ID_W'(r));
      end
   end

   assign out_id = nonempty ? head : '0;
   assign grant  = grant_q;
   assign busy   = (grant_q != '0) || nonempty;
   assign err    = err_q;

endmodule

// File: tb/tb_reverse_order_scheduler.sv
// Directed bench for reverse_order_scheduler; the bench itself plays the datapath output
// by driving dp_out_valid, with TAGD=2 so the full-FIFO case is reachable.
module tb_reverse_order_scheduler;
   localparam int unsigned BITS = 8;
   localparam int unsigned N    = 10;
   localparam int unsigned V    = 2;
   localparam int unsigned R    = 4;
   localparam int unsigned TAGD = 2;

   logic                          clk = 1'b0;
   logic                          rst_n;
   logic [R-1:0]                  req, in_valid;
   logic [R-1:0][V-1:0][BITS-1:0] data_in;
   logic [R-1:0]                  grant, out_valid;
   logic                          dp_in_valid, dp_out_valid;
   logic [V-1:0][BITS-1:0]        dp_data;
   logic [1:0]                    out_id;
   logic                          busy, err;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   reverse_order_scheduler #(
      .BITS(BITS), .N(N), .V(V), .R(R), .TAGD(TAGD)
   ) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .in_valid(in_valid), .data_in(data_in),
      .grant(grant), .dp_in_valid(dp_in_valid), .dp_data(dp_data),
      .dp_out_valid(dp_out_valid), .out_valid(out_valid), .out_id(out_id),
      .busy(busy), .err(err)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
      checks++;
      assert (obs === want) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
      end
   endtask

   // Inputs change 2 time units after the rising edge; checks follow 1 unit later.
   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   task automatic fill(input int unsigned b);
      for (int unsigned r = 0; r < R; r++) begin
         data_in[r][0] = 8'(b + 32 * r);
         data_in[r][1] = 8'(100 + b + 32 * r);
      end
   endtask

   function automatic logic [15:0] beat(input int unsigned r, input int unsigned b);
      return {8'(100 + b + 32 * r), 8'(b + 32 * r)};
   endfunction

   function automatic logic [3:0] oh(input int unsigned i);
      return 4'(1) << i;
   endfunction

   initial begin
      // Reset values, with inputs driven active to prove the combinational gating
      rst_n = 1'b0; req = '0; in_valid = '1; dp_out_valid = 1'b1; fill(7);
      #3;
      chk("rst_grant", grant, 0);
      chk("rst_dpv", dp_in_valid, 0);
      chk("rst_dpdata", dp_data, 0);
      chk("rst_outvalid", out_valid, 0);
      chk("rst_outid", out_id, 0);
      chk("rst_busy", busy, 0);
      chk("rst_err", err, 0);
      cyc(); cyc();
      dp_out_valid = 1'b0; in_valid = '0; rst_n = 1'b1;
      cyc();

      // Single frame from requester 2
      fill(50);
      req = 4'b0100; #1;
      chk("t1_pre_grant", grant, 0);
      cyc();
      req = '0;
      for (int unsigned i = 0; i < N; i++) begin
         in_valid = 4'b0100;
         data_in[2][0] = 8'(i);
         data_in[2][1] = 8'(100 + i);
         #1;
         chk("t1_grant", grant, 4'b0100);
         chk("t1_dpv", dp_in_valid, 1);
         chk("t1_dpdata", dp_data, {8'(100 + i), 8'(i)});
         cyc();
      end
      #1;
      chk("t1_end_grant", grant, 0);
      chk("t1_end_dpv", dp_in_valid, 0);
      chk("t1_end_dpdata", dp_data, 0);
      in_valid = '0;
      cyc();
      for (int unsigned j = 0; j < N; j++) begin
         dp_out_valid = 1'b1; #1;
         chk("t1_outvalid", out_valid, 4'b0100);
         chk("t1_outid", out_id, 2);
         chk("t1_busy", busy, 1);
         cyc();
      end
      dp_out_valid = 1'b0; #1;
      chk("t1_busy_done", busy, 0);
      chk("t1_err", err, 0);

      // Round-robin with all requesters asserted for 8 frames
      rst_n = 1'b0; #1; rst_n = 1'b1;
      cyc();
      req = '1;
      cyc();
      for (int unsigned f = 0; f < 8; f++) begin
         int unsigned e;
         e = f % 4;
         if (f == 7) req = '0;
         for (int unsigned b = 0; b < N; b++) begin
            in_valid = '1; fill(b); #1;
            if (b == 0) chk("rr_grant", grant, oh(e));
            chk("rr_dpdata", dp_data, beat(e, b));
            cyc();
         end
         in_valid = '0;
         for (int unsigned j = 0; j < N; j++) begin
            dp_out_valid = 1'b1; #1;
            chk("rr_outid", out_id, e);
            chk("rr_outvalid", out_valid, oh(e));
            if (j == 0) chk("rr_idle_gap", grant, 0);
            if (j == 1) chk("rr_next_grant", grant, (f < 7) ? oh((f + 1) % 4) : 4'b0000);
            cyc();
         end
         dp_out_valid = 1'b0;
      end
      #1;
      chk("rr_busy_done", busy, 0);
      chk("rr_grant_done", grant, 0);

      // Gapped input on requester 1 while requester 3 streams continuously
      rst_n = 1'b0; #1; rst_n = 1'b1;
      cyc();
      req = 4'b0010;
      cyc();
      req = '0;
      for (int unsigned c = 0; c < 20; c++) begin
         in_valid = {1'b1, 1'b0, (c % 2 == 0), 1'b0}; fill(c); #1;
         chk("gap_grant", grant, (c <= 18) ? 4'b0010 : 4'b0000);
         chk("gap_dpv", dp_in_valid, (c <= 18) && (c % 2 == 0));
         if (c <= 18 && c % 2 == 0) chk("gap_dpdata", dp_data, beat(1, c));
         cyc();
      end
      in_valid = '0;

      // Tag FIFO full: two frames in flight block the third until a pop
      rst_n = 1'b0; #1; rst_n = 1'b1;
      cyc();
      req = 4'b0111;
      cyc();
      for (int unsigned b = 0; b < N; b++) begin
         in_valid = 4'b0001; fill(b); #1;
         if (b == 0) chk("full_g0", grant, 4'b0001);
         cyc();
      end
      in_valid = '0;
      cyc();
      for (int unsigned b = 0; b < N; b++) begin
         in_valid = 4'b0010; fill(b); #1;
         if (b == 0) chk("full_g1", grant, 4'b0010);
         cyc();
      end
      in_valid = '0;
      for (int unsigned w = 0; w < 6; w++) begin
         #1;
         chk("full_block", grant, 0);
         chk("full_busy", busy, 1);
         cyc();
      end
      for (int unsigned j = 0; j < N; j++) begin
         dp_out_valid = 1'b1; #1;
         chk("full_outid0", out_id, 0);
         chk("full_block_drain", grant, 0);
         cyc();
      end
      for (int unsigned j = 0; j < N; j++) begin
         #1;
         chk("full_outid1", out_id, 1);
         if (j == 0) chk("full_pushpop_grant", grant, 4'b0100);
         cyc();
      end
      for (int unsigned j = 0; j < N; j++) begin
         #1;
         chk("full_outid2", out_id, 2);
         chk("full_outvalid2", out_valid, 4'b0100);
         cyc();
      end
      dp_out_valid = 1'b0; req = '0; #1;
      chk("full_err", err, 0);
      chk("full_busy_grant", busy, 1);

      // Error on stray output beat, then reset in the middle of a frame
      rst_n = 1'b0; #1; rst_n = 1'b1;
      cyc();
      dp_out_valid = 1'b1; #1;
      chk("e_outvalid", out_valid, 0);
      chk("e_err_pre", err, 0);
      cyc();
      dp_out_valid = 1'b0; #1;
      chk("e_err", err, 1);
      cyc();
      #1;
      chk("e_err_sticky", err, 1);
      req = 4'b0010;
      cyc();
      req = '0;
      for (int unsigned b = 0; b < N; b++) begin
         in_valid = 4'b0010; fill(b);
         cyc();
      end
      in_valid = '0; req = 4'b0100;
      cyc();
      req = '0;
      for (int unsigned b = 0; b < 4; b++) begin
         in_valid = 4'b0100; fill(b);
         cyc();
      end
      in_valid = 4'b0100; #1;
      chk("m_grant_pre", grant, 4'b0100);
      rst_n = 1'b0; #1;
      chk("m_rst_grant", grant, 0);
      chk("m_rst_err", err, 0);
      chk("m_rst_dpv", dp_in_valid, 0);
      chk("m_rst_busy", busy, 0);
      cyc();
      rst_n = 1'b1; in_valid = '0; req = '1; #1;
      chk("m_rel_grant", grant, 0);
      cyc();
      #1;
      chk("m_first_grant", grant, 4'b0001);
      req = '0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
